// File: rtl/core_inst_pkg.sv
// -----------------------------------------------------------------------------
// core_inst_pkg
// Shared definitions for the core instruction sequencer:
//   - bit positions of every field in the 34-bit core instruction word
//   - INST_IDLE: the quiescent instruction (memory enables/write enables high)
//   - sequencer state encoding
//   - inst_fields_t plus pack_inst(), which turn named fields into the
//     instruction word
//   - max3(), a small helper used to size the phase counters
// No ports (package).
// -----------------------------------------------------------------------------
package core_inst_pkg;

    localparam int INST_W = 34;
    localparam int ADDR_W = 11;

    // Instruction word bit positions
    localparam int B_ACC       = 33;
    localparam int B_CEN_PMEM  = 32;
    localparam int B_WEN_PMEM  = 31;
    localparam int B_A_PMEM_LO = 20;
    localparam int B_CEN_XMEM  = 19;
    localparam int B_WEN_XMEM  = 18;
    localparam int B_A_XMEM_LO = 7;
    localparam int B_OFIFO_RD  = 6;
    localparam int B_IFIFO_WR  = 5;
    localparam int B_IFIFO_RD  = 4;
    localparam int B_L0_RD     = 3;
    localparam int B_L0_WR     = 2;
    localparam int B_EXECUTE   = 1;
    localparam int B_LOAD      = 0;

    // Active-low memory enables and write enables high, everything else low
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_W_RD  = 4'd1,
        S_W_FL  = 4'd2,
        S_W_LD  = 4'd3,
        S_W_GAP = 4'd4,
        S_X_RD  = 4'd5,
        S_X_FL  = 4'd6,
        S_X_EX  = 4'd7,
        S_DRAIN = 4'd8,
        S_NEXT  = 4'd9,
        S_DONE  = 4'd10
    } seq_state_t;

    typedef struct packed {
        logic              acc;
        logic              cen_pmem;
        logic              wen_pmem;
        logic [ADDR_W-1:0] a_pmem;
        logic              cen_xmem;
        logic              wen_xmem;
        logic [ADDR_W-1:0] a_xmem;
        logic              ofifo_rd;
        logic              ififo_wr;
        logic              ififo_rd;
        logic              l0_rd;
        logic              l0_wr;
        logic              execute;
        logic              load;
    } inst_fields_t;

    function automatic logic [INST_W-1:0] pack_inst(input inst_fields_t f);
        logic [INST_W-1:0] w;
        w = '0;
        w[B_ACC]                     = f.acc;
        w[B_CEN_PMEM]                = f.cen_pmem;
        w[B_WEN_PMEM]                = f.wen_pmem;
        w[B_A_PMEM_LO +: ADDR_W]     = f.a_pmem;
        w[B_CEN_XMEM]                = f.cen_xmem;
        w[B_WEN_XMEM]                = f.wen_xmem;
        w[B_A_XMEM_LO +: ADDR_W]     = f.a_xmem;
        w[B_OFIFO_RD]                = f.ofifo_rd;
        w[B_IFIFO_WR]                = f.ififo_wr;
        w[B_IFIFO_RD]                = f.ififo_rd;
        w[B_L0_RD]                   = f.l0_rd;
        w[B_L0_WR]                   = f.l0_wr;
        w[B_EXECUTE]                 = f.execute;
        w[B_LOAD]                    = f.load;
        return w;
    endfunction

    // Field set equivalent to INST_IDLE
    function automatic inst_fields_t idle_fields();
        inst_fields_t f;
        f          = '0;
        f.cen_pmem = 1'b1;
        f.wen_pmem = 1'b1;
        f.cen_xmem = 1'b1;
        f.wen_xmem = 1'b1;
        return f;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/seq_phase_cnt.sv
// -----------------------------------------------------------------------------
// seq_phase_cnt
// Small phase counter with clear, load, increment and terminal-count compare.
// Clear has priority over load, load over increment.
// Ports:
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset
//   i_clr     in   synchronous clear to zero
//   i_ld      in   synchronous load of i_ld_val
//   i_ld_val  in   W  load value
//   i_inc     in   increment by one
//   i_tc_val  in   W  terminal-count value
//   o_cnt     out  W  current count
//   o_tc      out  high while o_cnt == i_tc_val
// -----------------------------------------------------------------------------
module seq_phase_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clr,
    input  logic         i_ld,
    input  logic [W-1:0] i_ld_val,
    input  logic         i_inc,
    input  logic [W-1:0] i_tc_val,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ld_val;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_tc_val);

endmodule

// File: rtl/core_inst_sequencer.sv
// -----------------------------------------------------------------------------
// core_inst_sequencer
// Generates the 34-bit core instruction word for one full convolution:
// for every kernel position it loads weights xmem -> L0 -> PE array, waits
// for the array to settle, streams activations through L0 while executing,
// then drains the output FIFO into pmem (accumulating for kij > 0).
// All outputs are registered: inst reflects the state of the previous cycle.
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   begin a convolution (only looked at in IDLE)
//   ofifo_valid  in   core output FIFO holds a psum row
//   inst         out  34  core instruction word
//   busy         out  high from accepted start until DONE
//   done         out  one-cycle pulse after the final psum write
//   kij          out  4   current kernel index
// -----------------------------------------------------------------------------
module core_inst_sequencer
    import core_inst_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_kij = 9,
    parameter int len_nij = 36,
    parameter int W_BASE  = 64,
    parameter int GAP     = row + col
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        kij
);

    localparam int CNT_W = $clog2(max3(len_nij, col, GAP) + 1);

    seq_state_t        r_state;
    logic [3:0]        r_kij;
    logic [INST_W-1:0] r_inst;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_pend;   // an ofifo read was issued last cycle

    seq_state_t        w_next;
    logic [3:0]        w_kij_next;
    inst_fields_t      w_f;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_cnt_tc;
    logic [CNT_W-1:0]  w_cnt_tcval;
    logic              w_cnt_clr;
    logic [CNT_W-1:0]  w_pcnt;
    logic              w_pcnt_tc;
    logic              w_pcnt_clr;
    logic              w_rd_issue;

    // Phase counter: restarts at zero on every state change
    assign w_cnt_clr = (w_next != r_state);

    seq_phase_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (w_cnt_clr),
        .i_ld     (1'b0),
        .i_ld_val ('0),
        .i_inc    (1'b1),
        .i_tc_val (w_cnt_tcval),
        .o_cnt    (w_cnt),
        .o_tc     (w_cnt_tc)
    );

    // Psum counter: number of pmem writes issued in the current drain
    assign w_pcnt_clr = (r_state != S_DRAIN);

    seq_phase_cnt #(.W(CNT_W)) u_pcnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (w_pcnt_clr),
        .i_ld     (1'b0),
        .i_ld_val ('0),
        .i_inc    (r_rd_pend),
        .i_tc_val (CNT_W'(len_nij - 1)),
        .o_cnt    (w_pcnt),
        .o_tc     (w_pcnt_tc)
    );

    always_comb begin
        w_next      = r_state;
        w_kij_next  = r_kij;
        w_cnt_tcval = '0;
        w_rd_issue  = 1'b0;
        w_f         = idle_fields();
        // xmem data lands one cycle after the read enable, so L0 write is the
        // read enable delayed by one stage; this alone yields one write per read.
        w_f.l0_wr   = ~r_inst[B_CEN_XMEM];

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next     = S_W_RD;
                    w_kij_next = '0;
                end
            end
            S_W_RD: begin
                w_cnt_tcval  = CNT_W'(col - 1);
                w_f.cen_xmem = 1'b0;
                w_f.a_xmem   = ADDR_W'(W_BASE) + ADDR_W'(r_kij) * ADDR_W'(col)
                             + ADDR_W'(w_cnt);
                if (w_cnt_tc) w_next = S_W_FL;
            end
            S_W_FL: begin
                w_next = S_W_LD;
            end
            S_W_LD: begin
                w_cnt_tcval = CNT_W'(col - 1);
                w_f.l0_rd   = 1'b1;
                w_f.load    = 1'b1;
                if (w_cnt_tc) w_next = S_W_GAP;
            end
            S_W_GAP: begin
                w_cnt_tcval = CNT_W'(GAP - 1);
                if (w_cnt_tc) w_next = S_X_RD;
            end
            S_X_RD: begin
                w_cnt_tcval  = CNT_W'(len_nij - 1);
                w_f.cen_xmem = 1'b0;
                w_f.a_xmem   = ADDR_W'(w_cnt);
                if (w_cnt_tc) w_next = S_X_FL;
            end
            S_X_FL: begin
                w_next = S_X_EX;
            end
            S_X_EX: begin
                w_cnt_tcval = CNT_W'(len_nij - 1);
                w_f.l0_rd   = 1'b1;
                w_f.execute = 1'b1;
                if (w_cnt_tc) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Count the read still in flight so we never over-read the FIFO
                w_rd_issue   = ofifo_valid &&
                               ((w_pcnt + CNT_W'(r_rd_pend)) < CNT_W'(len_nij));
                w_f.ofifo_rd = w_rd_issue;
                if (r_rd_pend) begin
                    w_f.cen_pmem = 1'b0;
                    w_f.wen_pmem = 1'b0;
                    w_f.a_pmem   = ADDR_W'(w_pcnt);
                    w_f.acc      = (r_kij != 4'd0);
                    if (w_pcnt_tc) w_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (r_kij == 4'(len_kij - 1)) begin
                    w_next = S_DONE;
                end else begin
                    w_kij_next = r_kij + 4'd1;
                    w_next     = S_W_RD;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_kij     <= '0;
            r_inst    <= INST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_pend <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_kij     <= w_kij_next;
            r_inst    <= pack_inst(w_f);
            r_busy    <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done    <= (w_next == S_DONE);
            r_rd_pend <= w_rd_issue;
        end
    end

    assign inst = r_inst;
    assign busy = r_busy;
    assign done = r_done;
    assign kij  = r_kij;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_inst_sequencer
// Directed bench for core_inst_sequencer with the default parameters
// (col=8, len_kij=9, len_nij=36, W_BASE=64). The output FIFO is a stub that
// raises ofifo_valid either every cycle or one cycle in three.
// -----------------------------------------------------------------------------
module tb_core_inst_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        ofifo_valid = 1'b0;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;

    core_inst_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .kij         (kij)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    // ---------------- scoreboard state ----------------
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [10:0] exp_xa_q[$];   // expected xmem read addresses, in order
    logic [11:0] exp_pw_q[$];   // expected pmem writes {acc, addr}, in order
    int          l0wr_n, load_n, exec_n, ofrd_n, pw_n, done_n;
    int          rel_err, busy_err;
    int          cyc_n = 0;
    int          valid_mode = 0;
    logic        prev_cen_x = 1'b1;
    logic        prev_ofrd  = 1'b0;
    logic        drv_valid  = 1'b0;
    logic        mon_en     = 1'b0;
    logic [10:0] xa_exp;
    logic [11:0] pw_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one cycle, sample at the falling edge, then drive ofifo_valid
    // for the next rising edge.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (mon_en) begin
            if (!inst[19]) begin
                if (exp_xa_q.size() == 0) begin
                    chk("xa_extra", 64'd1, 64'd0);
                end else begin
                    xa_exp = exp_xa_q.pop_front();
                    chk("xa_addr", 64'(inst[17:7]), 64'(xa_exp));
                end
            end
            if (inst[18] !== 1'b1) rel_err++;
            if (inst[2] !== ~prev_cen_x) rel_err++;
            if (inst[3] !== (inst[0] | inst[1])) rel_err++;
            if (inst[5] | inst[4]) rel_err++;
            if (inst[2]) l0wr_n++;
            if (inst[0]) load_n++;
            if (inst[1]) exec_n++;
            if (inst[6]) begin
                ofrd_n++;
                if (!drv_valid) rel_err++;
            end
            if (!inst[32]) begin
                pw_n++;
                if (inst[31] !== 1'b0 || !prev_ofrd) rel_err++;
                if (exp_pw_q.size() == 0) begin
                    chk("pw_extra", 64'd1, 64'd0);
                end else begin
                    pw_exp = exp_pw_q.pop_front();
                    chk("pw_acc_addr", 64'({inst[33], inst[30:20]}), 64'(pw_exp));
                end
            end
            if (done) done_n++;
        end
        prev_cen_x = inst[19];
        prev_ofrd  = inst[6];
        drv_valid  = (valid_mode == 0) ? 1'b1 : ((cyc_n % 3) == 0);
        ofifo_valid = drv_valid;
    endtask

    // One full convolution with queue-based checking of every xmem read and
    // pmem write, plus totals at the end.
    task automatic run_conv(input int mode, input bit gap_start);
        bit got_done;
        int extra;
        valid_mode = mode;
        exp_xa_q.delete();
        exp_pw_q.delete();
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 8; i++) exp_xa_q.push_back(11'(64 + k * 8 + i));
            for (int i = 0; i < 36; i++) exp_xa_q.push_back(11'(i));
            for (int a = 0; a < 36; a++) exp_pw_q.push_back({(k != 0), 11'(a)});
        end
        l0wr_n = 0; load_n = 0; exec_n = 0; ofrd_n = 0; pw_n = 0; done_n = 0;
        rel_err = 0; busy_err = 0;
        mon_en = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        got_done = 1'b0;
        extra = 0;
        for (int i = 0; i < 4000 && extra < 4; i++) begin
            if (gap_start) start = (i == 24);
            cyc();
            if (got_done) begin
                extra++;
                if (busy) busy_err++;
            end else if (done) begin
                got_done = 1'b1;
                chk("busy_at_done", 64'(busy), 64'd0);
                chk("kij_at_done", 64'(kij), 64'd8);
                chk("inst_at_done", 64'(inst), 64'(IDLE_WORD));
            end else if (!busy) begin
                busy_err++;
            end
        end
        start = 1'b0;
        chk("done_seen", 64'(got_done), 64'd1);
        chk("done_pulses", 64'(done_n), 64'd1);
        chk("xa_left", 64'(exp_xa_q.size()), 64'd0);
        chk("pw_left", 64'(exp_pw_q.size()), 64'd0);
        chk("l0_wr_count", 64'(l0wr_n), 64'd396);
        chk("load_count", 64'(load_n), 64'd72);
        chk("execute_count", 64'(exec_n), 64'd324);
        chk("ofifo_rd_count", 64'(ofrd_n), 64'd324);
        chk("pmem_wr_count", 64'(pw_n), 64'd324);
        chk("relation_errors", 64'(rel_err), 64'd0);
        chk("busy_errors", 64'(busy_err), 64'd0);
        mon_en = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit found;

        // Reset values
        reset_n = 1'b0;
        repeat (3) cyc();
        chk("rst_inst", 64'(inst), 64'(IDLE_WORD));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_kij", 64'(kij), 64'd0);
        reset_n = 1'b1;
        repeat (2) cyc();
        chk("idle_inst", 64'(inst), 64'(IDLE_WORD));
        chk("idle_busy", 64'(busy), 64'd0);

        // Full run, FIFO always valid, spurious start during the weight gap
        run_conv(0, 1'b1);

        // Full run, FIFO valid one cycle in three
        run_conv(1, 1'b0);

        // Abort mid-execute of kij 4 with an asynchronous reset
        valid_mode = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            cyc();
            if (kij == 4'd4 && inst[1]) found = 1'b1;
        end
        chk("reached_kij4_exec", 64'(found), 64'd1);
        repeat (5) cyc();
        chk("still_executing", 64'(inst[1]), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_inst", 64'(inst), 64'(IDLE_WORD));
        chk("abort_kij", 64'(kij), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        cyc();
        chk("abort_hold_inst", 64'(inst), 64'(IDLE_WORD));
        reset_n = 1'b1;
        cyc();

        // Normal run after the abort
        run_conv(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
